// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and stage indices for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        CtrlRun   = 2'd0,
        CtrlFlush = 2'd1,
        CtrlIdle  = 2'd2
    } ctrl_state_e;

    typedef logic [4:0] stage_vec_t;

    localparam int unsigned StgIf  = 0;
    localparam int unsigned StgId  = 1;
    localparam int unsigned StgEx  = 2;
    localparam int unsigned StgMem = 3;
    localparam int unsigned StgWb  = 4;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath and the controller: stage status in, stall/flush/redirect out.
interface pipeline_ctrl_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_AW = 5
);
    import pipeline_ctrl_pkg::*;

    stage_vec_t        stage_valid;
    logic [REG_AW-1:0] id_rj;
    logic [REG_AW-1:0] id_rk;
    logic              id_use_rj;
    logic              id_use_rk;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              ex_is_div;
    logic              ex_br_taken;
    logic [PC_W-1:0]   ex_br_target;
    logic              mem_is_load;
    logic              mem_data_ok;
    logic              wb_exc;
    logic              wb_ertn;
    logic              wb_idle;
    logic [PC_W-1:0]   wb_pc;
    logic [PC_W-1:0]   exc_entry;
    logic [PC_W-1:0]   era;
    logic              int_pending;

    stage_vec_t        ready_go;
    stage_vec_t        flush;
    logic              div_start;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [1:0]        state_o;

    // Controller side.
    modport master (
        input  stage_valid, id_rj, id_rk, id_use_rj, id_use_rk, ex_rd, ex_is_load, ex_is_div,
               ex_br_taken, ex_br_target, mem_is_load, mem_data_ok, wb_exc, wb_ertn, wb_idle,
               wb_pc, exc_entry, era, int_pending,
        output ready_go, flush, div_start, redirect_valid, redirect_pc, state_o
    );

    // Datapath side.
    modport slave (
        output stage_valid, id_rj, id_rk, id_use_rj, id_use_rk, ex_rd, ex_is_load, ex_is_div,
               ex_br_taken, ex_br_target, mem_is_load, mem_data_ok, wb_exc, wb_ertn, wb_idle,
               wb_pc, exc_entry, era, int_pending,
        input  ready_go, flush, div_start, redirect_valid, redirect_pc, state_o
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator between the ID sources and an EX load destination; r0 never hazards.
module pipeline_ctrl_hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rj_i,
    input  logic [REG_AW-1:0] id_rk_i,
    input  logic              id_use_rj_i,
    input  logic              id_use_rk_i,
    output logic              id_stall_o
);

    logic rj_hit;
    logic rk_hit;

    always_comb begin
        rj_hit     = id_use_rj_i & (id_rj_i == ex_rd_i);
        rk_hit     = id_use_rk_i & (id_rk_i == ex_rd_i);
        id_stall_o = ex_valid_i & ex_is_load_i & (ex_rd_i != '0) & (rj_hit | rk_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage ready_go/flush, divide occupancy, fetch redirect,
// and the RUN/FLUSH/IDLE sequencing around WB-committed exceptions, ertn and idle.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DIV_LAT = 17
) (
    input  logic             aclk,
    input  logic             aresetn,
    pipeline_ctrl_if.master  ctrl
);

    localparam int unsigned    CntW    = $clog2(DIV_LAT);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_LAT - 1);

    ctrl_state_e     state_q, state_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [PC_W-1:0] saved_pc_q, saved_pc_d;

    logic id_stall;
    logic ex_div;
    logic div_busy;
    logic mem_wait;
    logic in_run;
    logic trap_hit;
    logic idle_hit;
    logic br_hit;

    pipeline_ctrl_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid_i   (ctrl.stage_valid[StgEx]),
        .ex_is_load_i (ctrl.ex_is_load),
        .ex_rd_i      (ctrl.ex_rd),
        .id_rj_i      (ctrl.id_rj),
        .id_rk_i      (ctrl.id_rk),
        .id_use_rj_i  (ctrl.id_use_rj),
        .id_use_rk_i  (ctrl.id_use_rk),
        .id_stall_o   (id_stall)
    );

    // Event decode; priority is exc/ertn > idle > branch.
    always_comb begin
        in_run   = (state_q == CtrlRun);
        ex_div   = ctrl.stage_valid[StgEx] & ctrl.ex_is_div;
        div_busy = ex_div & (div_cnt_q != CntLast);
        mem_wait = ctrl.stage_valid[StgMem] & ctrl.mem_is_load & ~ctrl.mem_data_ok;
        trap_hit = in_run & ctrl.stage_valid[StgWb] & (ctrl.wb_exc | ctrl.wb_ertn);
        idle_hit = in_run & ctrl.stage_valid[StgWb] & ctrl.wb_idle & ~trap_hit;
        br_hit   = in_run & ctrl.stage_valid[StgEx] & ctrl.ex_br_taken & ~div_busy
                 & ~trap_hit & ~idle_hit;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= CtrlRun;
            div_cnt_q  <= '0;
            saved_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        saved_pc_d = saved_pc_q;
        unique case (state_q)
            CtrlRun: begin
                if (trap_hit) begin
                    state_d = CtrlFlush;
                end else if (idle_hit) begin
                    state_d    = CtrlIdle;
                    saved_pc_d = ctrl.wb_pc + PC_W'(4);
                end
            end
            CtrlFlush: state_d = CtrlRun;
            CtrlIdle: begin
                if (ctrl.int_pending) state_d = CtrlRun;
            end
            default: state_d = CtrlRun;
        endcase
    end

    always_comb begin
        ctrl.ready_go         = '1;
        ctrl.ready_go[StgId]  = ~id_stall;
        ctrl.ready_go[StgEx]  = ~div_busy;
        ctrl.ready_go[StgMem] = ~mem_wait;
        // Hold fetch while CSR state settles after a trap, and while sleeping.
        ctrl.ready_go[StgIf]  = in_run;
        ctrl.flush            = '0;
        ctrl.redirect_valid   = 1'b0;
        ctrl.redirect_pc      = '0;
        ctrl.div_start        = aresetn & in_run & ex_div & (div_cnt_q == '0);
        ctrl.state_o          = state_q;
        if (trap_hit) begin
            ctrl.flush[StgMem:StgIf] = '1;
            ctrl.redirect_valid      = 1'b1;
            ctrl.redirect_pc         = ctrl.wb_exc ? ctrl.exc_entry : ctrl.era;
        end else if (idle_hit) begin
            ctrl.flush[StgMem:StgIf] = '1;
        end else if (br_hit) begin
            ctrl.flush[StgId:StgIf]  = '1;
            ctrl.redirect_valid      = 1'b1;
            ctrl.redirect_pc         = ctrl.ex_br_target;
        end else if (state_q == CtrlIdle && ctrl.int_pending) begin
            ctrl.redirect_valid      = 1'b1;
            ctrl.redirect_pc         = saved_pc_q;
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (ctrl.flush[StgEx] || div_cnt_q == CntLast) begin
            div_cnt_d = '0;
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q + CntW'(1);
        end else if (ctrl.div_start) begin
            div_cnt_d = CntW'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned DIV_LAT = 17;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    pipeline_ctrl_if #(.PC_W(PC_W), .REG_AW(REG_AW)) pif ();

    pipeline_ctrl #(
        .PC_W    (PC_W),
        .REG_AW  (REG_AW),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .ctrl    (pif.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: state 0=RUN 1=FLUSH 2=IDLE; divide tracked by the cycle it started in.
    int              m_state  = 0;
    int              m_div_t0 = -1;
    logic [PC_W-1:0] m_saved  = '0;
    int              cyc      = 0;

    logic [4:0]      obs_rg, obs_fl;
    logic            obs_ds, obs_rv;
    logic [PC_W-1:0] obs_rp;
    logic [1:0]      obs_st;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clr_inputs();
        pif.stage_valid  = '0;
        pif.id_rj        = '0;
        pif.id_rk        = '0;
        pif.id_use_rj    = 1'b0;
        pif.id_use_rk    = 1'b0;
        pif.ex_rd        = '0;
        pif.ex_is_load   = 1'b0;
        pif.ex_is_div    = 1'b0;
        pif.ex_br_taken  = 1'b0;
        pif.ex_br_target = '0;
        pif.mem_is_load  = 1'b0;
        pif.mem_data_ok  = 1'b0;
        pif.wb_exc       = 1'b0;
        pif.wb_ertn      = 1'b0;
        pif.wb_idle      = 1'b0;
        pif.wb_pc        = '0;
        pif.exc_entry    = '0;
        pif.era          = '0;
        pif.int_pending  = 1'b0;
    endtask

    // One clock: evaluate model and sample DUT at negedge, advance model at posedge.
    task automatic step(input bit chk);
        logic [4:0]      v, e_rg, e_fl;
        logic            e_ds, e_rv;
        logic [PC_W-1:0] e_rp;
        int              nxt, elapsed;
        bit              start_now, idle_trig;
        @(negedge aclk);
        v = pif.stage_valid;
        e_rg = 5'b11111; e_fl = '0; e_rv = 1'b0; e_rp = '0; nxt = m_state; idle_trig = 0;
        if (v[2] && pif.ex_is_load && pif.ex_rd != 0 &&
            ((pif.id_use_rj && pif.id_rj == pif.ex_rd) ||
             (pif.id_use_rk && pif.id_rk == pif.ex_rd)))
            e_rg[1] = 1'b0;
        elapsed = (m_div_t0 < 0) ? 0 : (cyc - m_div_t0);
        if (v[2] && pif.ex_is_div && elapsed != DIV_LAT - 1) e_rg[2] = 1'b0;
        if (v[3] && pif.mem_is_load && !pif.mem_data_ok) e_rg[3] = 1'b0;
        if (m_state != 0) e_rg[0] = 1'b0;
        start_now = aresetn && m_state == 0 && v[2] && pif.ex_is_div && m_div_t0 < 0;
        e_ds = start_now;
        if (m_state == 0) begin
            if (v[4] && (pif.wb_exc || pif.wb_ertn)) begin
                e_fl = 5'b01111; e_rv = 1'b1; nxt = 1;
                e_rp = pif.wb_exc ? pif.exc_entry : pif.era;
            end else if (v[4] && pif.wb_idle) begin
                e_fl = 5'b01111; nxt = 2; idle_trig = 1;
            end else if (v[2] && pif.ex_br_taken && e_rg[2]) begin
                e_fl = 5'b00011; e_rv = 1'b1; e_rp = pif.ex_br_target;
            end
        end else if (m_state == 1) begin
            nxt = 0;
        end else if (pif.int_pending) begin
            e_rv = 1'b1; e_rp = m_saved; nxt = 0;
        end
        obs_rg = pif.ready_go; obs_fl = pif.flush; obs_ds = pif.div_start;
        obs_rv = pif.redirect_valid; obs_rp = pif.redirect_pc; obs_st = pif.state_o;
        if (chk) begin
            check_eq("ready_go", 64'(obs_rg), 64'(e_rg));
            check_eq("flush", 64'(obs_fl), 64'(e_fl));
            check_eq("div_start", 64'(obs_ds), 64'(e_ds));
            check_eq("redirect_valid", 64'(obs_rv), 64'(e_rv));
            if (e_rv) check_eq("redirect_pc", 64'(obs_rp), 64'(e_rp));
            check_eq("state", 64'(obs_st), 64'(m_state));
        end
        @(posedge aclk);
        if (!aresetn) begin
            m_state = 0; m_div_t0 = -1; m_saved = '0;
        end else begin
            m_state = nxt;
            if (e_fl[2] || (m_div_t0 >= 0 && elapsed == DIV_LAT - 1)) m_div_t0 = -1;
            else if (start_now) m_div_t0 = cyc;
            if (idle_trig) m_saved = pif.wb_pc + PC_W'(4);
        end
        cyc++;
        #1;
    endtask

    initial begin
        clr_inputs();
        aresetn = 1'b0;
        step(0);
        step(1);
        aresetn = 1'b1;
        step(1);
        check_eq("rst_ready_go", 64'(obs_rg), 64'h1f);
        check_eq("rst_flush", 64'(obs_fl), 64'h0);

        // Load-use on rj, then the same with r0 as destination.
        pif.stage_valid = 5'b11111; pif.ex_is_load = 1'b1; pif.ex_rd = 5'd5;
        pif.id_rj = 5'd5; pif.id_use_rj = 1'b1;
        step(1);
        check_eq("lu_stall", 64'(obs_rg), 64'h1d);
        pif.ex_rd = 5'd0; pif.id_rj = 5'd0;
        step(1);
        check_eq("lu_r0", 64'(obs_rg), 64'h1f);
        clr_inputs();

        // Divide occupancy.
        pif.stage_valid = 5'b00100; pif.ex_is_div = 1'b1;
        for (int k = 0; k < DIV_LAT; k++) begin
            step(1);
            check_eq("div_pulse", 64'(obs_ds), 64'(k == 0));
            check_eq("div_rg2", 64'(obs_rg[2]), 64'(k == DIV_LAT - 1));
        end
        clr_inputs();
        step(1);

        // Branch redirect.
        pif.stage_valid = 5'b00100; pif.ex_br_taken = 1'b1; pif.ex_br_target = 32'h1C00_0100;
        step(1);
        check_eq("br_flush", 64'(obs_fl), 64'h03);
        check_eq("br_rv", 64'(obs_rv), 64'h1);
        check_eq("br_pc", 64'(obs_rp), 64'h1C00_0100);
        check_eq("br_state", 64'(obs_st), 64'h0);
        clr_inputs();

        // Exception wins over a same-cycle branch.
        pif.stage_valid = 5'b10100; pif.wb_exc = 1'b1; pif.exc_entry = 32'h1C00_8000;
        pif.ex_br_taken = 1'b1; pif.ex_br_target = 32'h1C00_0200;
        step(1);
        check_eq("exc_flush", 64'(obs_fl), 64'h0f);
        check_eq("exc_pc", 64'(obs_rp), 64'h1C00_8000);
        clr_inputs();
        step(1);
        check_eq("exc_st_flush", 64'(obs_st), 64'h1);
        check_eq("exc_rg0", 64'(obs_rg[0]), 64'h0);
        step(1);
        check_eq("exc_st_run", 64'(obs_st), 64'h0);

        // Idle and wake-up.
        pif.stage_valid = 5'b10000; pif.wb_idle = 1'b1; pif.wb_pc = 32'h1C00_0040;
        step(1);
        check_eq("idle_flush", 64'(obs_fl), 64'h0f);
        clr_inputs();
        for (int k = 0; k < 20; k++) begin
            step(1);
            check_eq("idle_hold", 64'({obs_st, obs_rg[0]}), 64'({2'd2, 1'b0}));
        end
        pif.int_pending = 1'b1;
        step(1);
        check_eq("wake_pc", 64'(obs_rp), 64'h1C00_0044);
        pif.int_pending = 1'b0;
        step(1);
        check_eq("wake_run", 64'(obs_st), 64'h0);

        // Reset in the middle of a divide, then a full restart.
        pif.stage_valid = 5'b00100; pif.ex_is_div = 1'b1;
        for (int k = 0; k < 8; k++) step(1);
        aresetn = 1'b0; pif.ex_is_div = 1'b0;
        step(1);
        aresetn = 1'b1;
        step(1);
        check_eq("rstdiv_rg", 64'(obs_rg), 64'h1f);
        check_eq("rstdiv_ds", 64'(obs_ds), 64'h0);
        check_eq("rstdiv_st", 64'(obs_st), 64'h0);
        pif.ex_is_div = 1'b1;
        for (int k = 0; k < DIV_LAT; k++) begin
            step(1);
            check_eq("redo_rg2", 64'(obs_rg[2]), 64'(k == DIV_LAT - 1));
        end
        clr_inputs();

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            aresetn          = ($urandom_range(0, 99) != 0);
            pif.stage_valid  = 5'($urandom);
            pif.id_rj        = 5'($urandom_range(0, 3));
            pif.id_rk        = 5'($urandom_range(0, 3));
            pif.id_use_rj    = 1'($urandom);
            pif.id_use_rk    = 1'($urandom);
            pif.ex_rd        = 5'($urandom_range(0, 3));
            pif.ex_is_load   = 1'($urandom);
            pif.ex_is_div    = ($urandom_range(0, 2) == 0);
            pif.ex_br_taken  = ($urandom_range(0, 3) == 0);
            pif.ex_br_target = $urandom;
            pif.mem_is_load  = 1'($urandom);
            pif.mem_data_ok  = 1'($urandom);
            pif.wb_exc       = ($urandom_range(0, 15) == 0);
            pif.wb_ertn      = ($urandom_range(0, 15) == 0);
            pif.wb_idle      = ($urandom_range(0, 19) == 0);
            pif.wb_pc        = (k % 7 == 0) ? 32'hFFFF_FFFC : $urandom;
            pif.exc_entry    = $urandom;
            pif.era          = $urandom;
            pif.int_pending  = ($urandom_range(0, 7) == 0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
